// File: rtl/spr_rom_fetch_pkg.sv
// Shared state type, default widths and cache sizing helpers for the sprite ROM fetch bridge.
// The optional word cache is built only when SPR_ROM_CACHE_EN is defined.
package spr_rom_fetch_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StDl} fetch_state_e;

    localparam int unsigned DefAddrW = 19;
    localparam int unsigned DefDataW = 32;

    function automatic int unsigned cache_idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned cache_tag_w(input int unsigned addr_w,
                                                input int unsigned lines);
        return addr_w - $clog2(lines);
    endfunction

endpackage

// File: rtl/spr_rom_fetch_cache.sv
// Direct-mapped word cache for the sprite ROM fetch bridge (used under SPR_ROM_CACHE_EN).
// Lookup is combinational; writes and the flush-all take effect on the clock edge.
module spr_rom_fetch_cache
    import spr_rom_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned LINES  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    localparam int unsigned IdxW = cache_idx_w(LINES);
    localparam int unsigned TagW = cache_tag_w(ADDR_W, LINES);

    logic [TagW-1:0]   tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [LINES-1:0]  valid_q;

    logic [IdxW-1:0] rd_idx;
    logic [IdxW-1:0] wr_idx;
    logic [TagW-1:0] rd_tag;
    logic [TagW-1:0] wr_tag;

    assign rd_idx = lookup_addr[IdxW-1:0];
    assign rd_tag = lookup_addr[ADDR_W-1:IdxW];
    assign wr_idx = wr_addr[IdxW-1:0];
    assign wr_tag = wr_addr[ADDR_W-1:IdxW];

    assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign hit_data = data_q[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/spr_rom_fetch.sv
// Sprite ROM word fetcher: one SDRAM read per new word address, last word held for the pixel path.
// Define SPR_ROM_CACHE_EN to serve repeated addresses from a small direct-mapped cache.
module spr_rom_fetch
    import spr_rom_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned CACHE_LINES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_dout,
    output logic              rom_ready,
    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_addr,
    input  logic              sdr_ack,
    input  logic [DATA_W-1:0] sdr_data
);
    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] done_addr_q;
    logic [ADDR_W-1:0] sdr_addr_q;
    logic [DATA_W-1:0] rom_dout_q;
    logic              done_valid_q;
    logic              rom_ready_q;
    logic              sdr_req_q;

    logic              new_addr;
    logic              ack_match;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_data;
    logic              issue;
    logic              hit_load;
    logic              req_done;
    logic              accept;
    logic              flush;

    assign new_addr  = !done_valid_q || (cur_addr_q != done_addr_q);
    assign ack_match = (sdr_addr_q == cur_addr_q);

`ifdef SPR_ROM_CACHE_EN
    spr_rom_fetch_cache #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LINES  (CACHE_LINES)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .lookup_addr (cur_addr_q),
        .hit         (cache_hit),
        .hit_data    (cache_data),
        .wr_en       (accept),
        .wr_addr     (sdr_addr_q),
        .wr_data     (sdr_data)
    );
`else
    logic unused_cache_cfg;
    assign unused_cache_cfg = ^CACHE_LINES;
    assign cache_hit        = 1'b0;
    assign cache_data       = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ioctl_download) begin
            state_d = StDl;
        end else begin
            unique case (state_q)
                StIdle:  if (new_addr && !cache_hit) state_d = StReq;
                StReq:   if (sdr_ack) state_d = StIdle;
                StDl:    state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        issue    = 1'b0;
        hit_load = 1'b0;
        req_done = 1'b0;
        accept   = 1'b0;
        flush    = 1'b0;
        if (ioctl_download) begin
            flush = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (new_addr) begin
                        hit_load = cache_hit;
                        issue    = !cache_hit;
                    end
                end
                StReq: begin
                    // An ack for an address the sprite block has moved away from is dropped.
                    req_done = sdr_ack;
                    accept   = sdr_ack && ack_match;
                end
                StDl:    flush = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr_q   <= '0;
            done_addr_q  <= '0;
            done_valid_q <= 1'b0;
            rom_dout_q   <= '0;
            rom_ready_q  <= 1'b0;
            sdr_req_q    <= 1'b0;
            sdr_addr_q   <= '0;
        end else begin
            cur_addr_q  <= rom_addr;
            rom_ready_q <= done_valid_q && (done_addr_q == cur_addr_q);
            if (flush) begin
                sdr_req_q    <= 1'b0;
                done_valid_q <= 1'b0;
            end
            if (issue) begin
                sdr_req_q  <= 1'b1;
                sdr_addr_q <= cur_addr_q;
            end
            if (req_done) begin
                sdr_req_q <= 1'b0;
            end
            if (accept) begin
                rom_dout_q   <= sdr_data;
                done_addr_q  <= sdr_addr_q;
                done_valid_q <= 1'b1;
            end
            if (hit_load) begin
                rom_dout_q   <= cache_data;
                done_addr_q  <= cur_addr_q;
                done_valid_q <= 1'b1;
            end
        end
    end

    assign rom_dout  = rom_dout_q;
    assign rom_ready = rom_ready_q;
    assign sdr_req   = sdr_req_q;
    assign sdr_addr  = sdr_addr_q;

endmodule

// File: tb/tb_spr_rom_fetch.sv
// Self-checking bench for spr_rom_fetch: directed scenarios plus random address streams,
// checked against a transaction-level model of ROM contents, held word and cache lines.
module tb_spr_rom_fetch;
    localparam int unsigned AW    = 19;
    localparam int unsigned DW    = 32;
    localparam int unsigned LINES = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic          rom_ready;
    logic          sdr_req;
    logic [AW-1:0] sdr_addr;
    logic          sdr_ack;
    logic [DW-1:0] sdr_data;

    spr_rom_fetch #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .CACHE_LINES (LINES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .rom_ready      (rom_ready),
        .sdr_req        (sdr_req),
        .sdr_addr       (sdr_addr),
        .sdr_ack        (sdr_ack),
        .sdr_data       (sdr_data)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Model: ROM contents, the word currently held, and which addresses the cache holds.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          mdl_valid;
    logic [AW-1:0] mdl_done;
    logic [DW-1:0] mdl_dout;
    bit            c_valid [LINES];
    int unsigned   c_tag   [LINES];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] a);
        int unsigned ai;
        ai = a;
`ifdef SPR_ROM_CACHE_EN
        return c_valid[ai % LINES] && (c_tag[ai % LINES] == ai / LINES);
`else
        return (ai == 0) && 1'b0;
`endif
    endfunction

    task automatic model_fill(input logic [AW-1:0] a);
        int unsigned ai;
        ai = a;
        c_valid[ai % LINES] = 1'b1;
        c_tag[ai % LINES]   = ai / LINES;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) c_valid[i] = 1'b0;
        mdl_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with sdr_req expected high for address a; answers after waitc cycles.
    task automatic serve(input logic [AW-1:0] a, input int unsigned waitc);
        logic [DW-1:0] d;
        d = word_at(a);
        check("req_up", sdr_req, 1);
        check("req_addr", sdr_addr, a);
        for (int i = 0; i < waitc; i++) begin
            tick();
            check("req_hold", sdr_req, 1);
            check("addr_hold", sdr_addr, a);
        end
        sdr_ack  = 1'b1;
        sdr_data = d;
        tick();
        sdr_ack  = 1'b0;
        sdr_data = $urandom;
        check("dout_ack", rom_dout, d);
        check("req_drop", sdr_req, 0);
        check("ready_lag", rom_ready, 0);
        tick();
        check("ready_up", rom_ready, 1);
        check("no_reissue", sdr_req, 0);
        check("dout_hold", rom_dout, d);
        mdl_valid = 1'b1;
        mdl_done  = a;
        mdl_dout  = d;
        model_fill(a);
    endtask

    task automatic access(input logic [AW-1:0] a, input int unsigned waitc);
        if (mdl_valid && (a == mdl_done)) begin
            rom_addr = a;
            repeat (3) tick();
            check("same_ready", rom_ready, 1);
            check("same_noreq", sdr_req, 0);
            check("same_dout", rom_dout, mdl_dout);
            return;
        end
        rom_addr = a;
        tick();
        check("req_quiet", sdr_req, 0);
        tick();
        check("ready_fall", rom_ready, 0);
        if (model_hit(a)) begin
            check("hit_noreq", sdr_req, 0);
            check("hit_dout", rom_dout, word_at(a));
            tick();
            check("hit_ready", rom_ready, 1);
            check("hit_noreq2", sdr_req, 0);
            mdl_valid = 1'b1;
            mdl_done  = a;
            mdl_dout  = word_at(a);
        end else begin
            serve(a, waitc);
        end
    endtask

    task automatic spurious_ack();
        sdr_ack  = 1'b1;
        sdr_data = $urandom;
        tick();
        sdr_ack = 1'b0;
        check("spur_dout", rom_dout, mdl_dout);
        check("spur_req", sdr_req, 0);
        check("spur_ready", rom_ready, 1);
        tick();
        check("spur_dout2", rom_dout, mdl_dout);
        check("spur_ready2", rom_ready, 1);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        rom_addr       = '0;
        sdr_ack        = 1'b0;
        sdr_data       = '0;
        mdl_dout       = '0;
        mdl_done       = '0;
        model_clear();
        mem[19'h12345] = 32'hDEADBEEF;
        mem[19'h00005] = 32'hA5A5A5A5;

        repeat (3) tick();
        check("rst_dout", rom_dout, 0);
        check("rst_ready", rom_ready, 0);
        check("rst_req", sdr_req, 0);
        check("rst_addr", sdr_addr, 0);

        // After reset done_valid is 0, so address 0 is fetched immediately.
        reset = 1'b0;
        tick();
        serve(19'h0, 1);

        access(19'h12345, 3);

        // Retarget while a request is pending: first ack must be dropped.
        rom_addr = 19'h00010;
        tick();
        tick();
        check("rt_req", sdr_req, 1);
        check("rt_addr", sdr_addr, 19'h00010);
        rom_addr = 19'h00020;
        tick();
        tick();
        check("rt_pending", sdr_req, 1);
        sdr_ack  = 1'b1;
        sdr_data = 32'h0BAD0BAD;
        tick();
        sdr_ack = 1'b0;
        check("rt_discard", rom_dout, mdl_dout);
        check("rt_req_drop", sdr_req, 0);
        tick();
        serve(19'h00020, 1);

        spurious_ack();

        // Download during a request: abandon, ignore late ack, refetch afterwards.
        rom_addr = 19'h00077;
        tick();
        tick();
        check("dl_req_up", sdr_req, 1);
        ioctl_download = 1'b1;
        tick();
        check("dl_req_drop", sdr_req, 0);
        sdr_ack  = 1'b1;
        sdr_data = $urandom;
        tick();
        sdr_ack = 1'b0;
        check("dl_late_ack", rom_dout, mdl_dout);
        check("dl_ready", rom_ready, 0);
        ioctl_download = 1'b0;
        model_clear();
        tick();
        check("dl_exit_noreq", sdr_req, 0);
        tick();
        serve(19'h00077, 2);

        access(19'h00005, 1);
        access(19'h00006, 0);
        access(19'h00005, 2);
        access(19'h00015, 1);
        access(19'h00005, 0);

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 3) * 16 + $urandom_range(0, 3));
            access(a, $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) spurious_ack();
        end

        // Asynchronous reset in the middle of a request.
        rom_addr = 19'h7FFFF;
        tick();
        tick();
        check("mr_req_up", sdr_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_req", sdr_req, 0);
        check("mr_dout", rom_dout, 0);
        check("mr_ready", rom_ready, 0);
        check("mr_addr", sdr_addr, 0);
        rom_addr = '0;
        sdr_ack  = 1'b1;
        sdr_data = 32'h5555AAAA;
        model_clear();
        mdl_dout = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        sdr_ack = 1'b0;
        check("mr_ack_ignored", rom_dout, 0);
        serve(19'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/spr_rom_fetch.md
# spr_rom_fetch

Bridges the sprite pipeline's graphics-ROM word address to the shared SDRAM read port. It sits directly upstream of the sprite block's `spr_rom_dout` input. It watches the 19-bit sprite ROM word address and issues one SDRAM read per new address. It holds the last fetched 32-bit word stable for the K051937 pixel path, and optionally serves repeats from a small direct-mapped cache.

## Interface
Parameters:
- ADDR_W, 19, sprite ROM word-address width (32-bit words)
- DATA_W, 32, ROM word width
- CACHE_LINES, 16, cache entries; power of two, 2..256; ignored without the cache macro

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ioctl_download  in  1  ROM loader owns SDRAM; block goes idle
- rom_addr  in  ADDR_W  word address from sprite block
- rom_dout  out  DATA_W  word for the last completed address (chunky, unreordered)
- rom_ready  out  1  high when rom_dout corresponds to the current rom_addr
- sdr_req  out  1  read request level
- sdr_addr  out  ADDR_W  request address, stable while sdr_req is high
- sdr_ack  in  1  one-cycle pulse; sdr_data is valid in that cycle
- sdr_data  in  DATA_W  SDRAM read data

## Operation
- Address tracking:
  - rom_addr is registered every cycle into cur_addr.
  - "New address" means cur_addr differs from done_addr, or done_valid is 0.
- FSM states:
  - IDLE, then REQ on a new address with ioctl_download low.
  - REQ, then IDLE on sdr_ack.
  - DL: entered from any state when ioctl_download is high; left to IDLE when it falls.
- IDLE, new address: sdr_addr <= cur_addr, sdr_req <= 1, go to REQ.
- REQ: hold sdr_req and sdr_addr; the address is not retargeted mid-request.
- On sdr_ack:
  - sdr_req <= 0.
  - If sdr_addr == cur_addr: rom_dout <= sdr_data, done_addr <= sdr_addr, done_valid <= 1.
  - Otherwise the data is discarded, rom_dout is held, and IDLE reissues for cur_addr next cycle.
- rom_ready = done_valid & (done_addr == cur_addr), registered.
- sdr_ack outside REQ is ignored.
- DL state:
  - sdr_req forced 0; rom_dout held.
  - done_valid cleared; cache valid bits cleared.
  - A request outstanding at DL entry is abandoned; a late sdr_ack is ignored.
- Reset values: rom_dout 0, rom_ready 0, sdr_req 0, sdr_addr 0, cur_addr 0, done_addr 0, done_valid 0, state IDLE, all cache valid bits 0.
- Reset mid-request drops sdr_req asynchronously. No ack is expected afterwards.

## Timing
- rom_addr change at edge N:
  - cur_addr is updated at N+1.
  - sdr_req rises at N+2.
- sdr_ack at edge A: rom_dout and done_valid are updated at A+1, and rom_ready rises at A+2.
- Miss latency from address change to rom_ready = 4 + SDRAM wait cycles.
- Back-to-back: the next sdr_req can rise the cycle after the ack edge. There is never more than one outstanding request.
- The address is stable for at least 8 clk per fetch at the 24 MHz sprite rate, so steady state needs SDRAM latency ≤ 4 clk.

## Configuration
- SPR_ROM_CACHE_EN defined:
  - Direct-mapped cache of CACHE_LINES words; index = low log2(CACHE_LINES) address bits, tag = the remaining bits.
  - In IDLE, a new address is looked up first.
  - Hit: rom_dout <= line data and done_addr <= cur_addr at N+2, rom_ready at N+3; no SDRAM request.
  - Miss: issue sdr_req at N+2 as above; on accepted ack, write the line and set its valid bit.
  - Discarded acks do not fill the cache.
- Undefined: no cache storage; every new address goes to SDRAM.

## Structure
- Package spr_rom_fetch_pkg holds:
  - state enum (IDLE, REQ, DL);
  - default ADDR_W/DATA_W localparams;
  - the index/tag width function of CACHE_LINES.
- Sub-module spr_rom_fetch_cache, present only under SPR_ROM_CACHE_EN:
  - tag/data/valid arrays;
  - combinational lookup, synchronous write port;
  - single-cycle flush-all input.

## Test plan
- Reset then rom_addr=0x12345, sdr_ack after 3 cycles with data 0xDEADBEEF -> sdr_addr=0x12345, rom_dout=0xDEADBEEF, rom_ready high 2 cycles after ack.
- Change rom_addr 0x00010 to 0x00020 while the first request is pending -> first ack is discarded, rom_dout unchanged, second request for 0x00020 is issued the cycle after, its data is delivered.
- ioctl_download pulsed high during REQ -> sdr_req drops next cycle, a late ack leaves rom_dout unchanged, and after the fall the same address is refetched (done_valid cleared).
- Spurious sdr_ack in IDLE -> no change to any output.
- With SPR_ROM_CACHE_EN:
  - Fetch 0x00005 (data 0xA5A5A5A5), then 0x00006, then 0x00005 -> the third access issues no sdr_req and rom_ready rises 3 cycles after the address change.
  - 0x00005 then 0x00015 (same index, 16 lines) -> miss and refill; 0x00005 then misses again.
- Assert reset mid-request -> all outputs return to their reset values immediately; a subsequent ack is ignored.
